// File: rtl/mux_2_1.sv
// -----------------------------------------------------------------------------
// mux_2_1
//   Two-channel select cell. The combinational output s passes i1 when sel=1
//   and i0 otherwise, with no dependence on clk or rst. Alongside it, a small
//   amount of clocked bookkeeping tracks the select line:
//     - s_q     : s registered one cycle late
//     - sel_chg : one-cycle pulse when sampled sel differs from the previous
//                 sampled sel
//     - sw_cnt  : saturating count of sampled sel changes since reset
//
// Ports
//   clk      in   1       system clock, rising edge
//   rst      in   1       synchronous reset, active-high
//   i0       in   WIDTH   channel 0 data
//   i1       in   WIDTH   channel 1 data
//   sel      in   1       channel select: 0 -> i0, 1 -> i1
//   s        out  WIDTH   combinational mux output
//   s_q      out  WIDTH   registered mux output
//   sel_chg  out  1       one-cycle select-change pulse
//   sw_cnt   out  CNT_W   saturating count of select changes
// -----------------------------------------------------------------------------
module mux_2_1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] sw_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] s_d;
    logic             sel_prev_d;
    logic             sel_prev_q;
    logic             sel_chg_d;
    logic             sel_chg_q;
    logic [CNT_W-1:0] sw_cnt_d;
    logic [CNT_W-1:0] sw_cnt_q;

    // Ternary keeps X propagation on an unknown select in simulation.
    assign s = sel ? i1 : i0;

    always_comb begin
        s_d        = s;
        sel_prev_d = sel;
        sel_chg_d  = (sel != sel_prev_q);
        sw_cnt_d   = sw_cnt_q;
        // Hold at all-ones instead of wrapping back to zero.
        if (sel_chg_d && (sw_cnt_q != CNT_MAX)) begin
            sw_cnt_d = sw_cnt_q + 1'b1;
        end
    end

    // Reset wins over a select change on the same edge, so that change is
    // neither pulsed nor counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= '0;
            sel_prev_q <= 1'b0;
            sel_chg_q  <= 1'b0;
            sw_cnt_q   <= '0;
        end else begin
            s_q        <= s_d;
            sel_prev_q <= sel_prev_d;
            sel_chg_q  <= sel_chg_d;
            sw_cnt_q   <= sw_cnt_d;
        end
    end

    assign sel_chg = sel_chg_q;
    assign sw_cnt  = sw_cnt_q;

endmodule

// File: tb/tb_mux_2_1.sv
module tb_mux_2_1;

    localparam int W       = 4;
    localparam int CNT_W_A = 8;
    localparam int CNT_W_B = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   i0 = '0;
    logic [W-1:0]   i1 = '0;
    logic           sel = 1'b0;

    logic [W-1:0]       s_a, s_q_a, s_b, s_q_b;
    logic               chg_a, chg_b;
    logic [CNT_W_A-1:0] cnt_a;
    logic [CNT_W_B-1:0] cnt_b;

    mux_2_1 #(.WIDTH(W), .CNT_W(CNT_W_A)) dut_a (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .sel(sel),
        .s(s_a), .s_q(s_q_a), .sel_chg(chg_a), .sw_cnt(cnt_a)
    );

    mux_2_1 #(.WIDTH(W), .CNT_W(CNT_W_B)) dut_b (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .sel(sel),
        .s(s_b), .s_q(s_q_b), .sel_chg(chg_b), .sw_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [W-1:0] sq;
        logic         chg;
        int           cnt_a;
        int           cnt_b;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: last sampled select plus a plain integer change tally.
    logic model_prev = 1'b0;
    int   model_changes = 0;

    function automatic int sat(input int v, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Apply one cycle of stimulus at the falling edge; optionally glitch sel
    // and data between edges with no net change in sel.
    task automatic drive(input logic r, input logic sl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit glitch);
        exp_t e;
        logic [W-1:0] mux_v;
        @(negedge clk);
        rst = r; sel = sl; i0 = a; i1 = b;
        #1;
        mux_v = sl ? b : a;
        check("s_comb_a", 32'(s_a), 32'(mux_v));
        check("s_comb_b", 32'(s_b), 32'(mux_v));
        if (glitch) begin
            sel = ~sl; i0 = ~a; i1 = ~b;
            #1;
            check("s_glitch", 32'(s_a), 32'(sel ? i1 : i0));
            sel = sl; i0 = a; i1 = b;
            #1;
        end
        if (r) begin
            e.sq = '0; e.chg = 1'b0;
            model_prev = 1'b0; model_changes = 0;
        end else begin
            e.sq  = mux_v;
            e.chg = (sl != model_prev);
            if (e.chg) model_changes++;
            model_prev = sl;
        end
        e.cnt_a = sat(model_changes, CNT_W_A);
        e.cnt_b = sat(model_changes, CNT_W_B);
        exp_q.push_back(e);
    endtask

    // Monitor: every rising edge that has pending stimulus is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("s_q_a",     32'(s_q_a), 32'(e.sq));
                check("s_q_b",     32'(s_q_b), 32'(e.sq));
                check("sel_chg_a", 32'(chg_a), 32'(e.chg));
                check("sel_chg_b", 32'(chg_b), 32'(e.chg));
                check("sw_cnt_a",  32'(cnt_a), 32'(e.cnt_a));
                check("sw_cnt_b",  32'(cnt_b), 32'(e.cnt_b));
            end
        end
    end

    initial begin
        logic cur;
        int   pulses;
        // Reset, then the all-zero case.
        repeat (3) drive(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, '0, '0, 1'b0);

        // sel=0 then sel=1 with i0 toggling faster than i1.
        for (int k = 0; k < 20; k++)
            drive(1'b0, 1'b0, (k % 2) ? 4'hA : 4'h5, (k / 5 % 2) ? 4'hF : 4'h0, 1'b0);
        for (int k = 0; k < 20; k++)
            drive(1'b0, 1'b1, (k % 2) ? 4'hA : 4'h5, (k / 5 % 2) ? 4'hF : 4'h0, 1'b0);

        // Ten held-select phases, each flipping sel once: 10 changes here.
        repeat (2) drive(1'b1, 1'b0, '0, '0, 1'b0);
        cur = 1'b0;
        pulses = 0;
        for (int p = 0; p < 10; p++) begin
            cur = ~cur;
            for (int k = 0; k < 10; k++)
                drive(1'b0, cur, W'($urandom), W'($urandom), k == 5);
        end
        repeat (2) drive(1'b0, cur, W'($urandom), W'($urandom), 1'b0);
        @(negedge clk);
        check("sw_cnt_after_10", 32'(cnt_a), 32'd10);
        check("sw_cnt_sat_cnt2", 32'(cnt_b), 32'd3);

        // Reset applied while sel changes mid-count.
        drive(1'b0, ~cur, 4'h3, 4'hC, 1'b0);
        drive(1'b1,  cur, 4'h3, 4'hC, 1'b0);
        drive(1'b0,  cur, 4'h6, 4'h9, 1'b0);

        // Long random run with glitches and occasional resets; enough
        // changes to push the 8-bit counter into saturation.
        for (int k = 0; k < 700; k++)
            drive(($urandom_range(0, 199) == 0), 1'($urandom), W'($urandom),
                  W'($urandom), ($urandom_range(0, 7) == 0));
        for (int k = 0; k < 600; k++)
            drive(1'b0, k[0], W'($urandom), W'($urandom), 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("sw_cnt_sat_cnt8", 32'(cnt_a), 32'd255);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
